// File: rtl/clk_div_prog_if.sv
// Control/status bundle for clk_div_prog.
//   master: drives en, load, div_ratio; observes the divider outputs.
//   slave : the divider itself.
// Signals:
//   en           run request (1 = divide, 0 = stop at next period boundary)
//   load         one-cycle strobe capturing div_ratio
//   div_ratio    requested ratio N (0 = stop, 1 is clamped to 2)
//   div_out      divided square wave
//   div_out_n    complement of div_out
//   tick         one-cycle pulse on the last cycle of each period
//   ratio_active ratio currently in use
//   running      1 while the divider is running
interface clk_div_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div_ratio;
    logic             div_out;
    logic             div_out_n;
    logic             tick;
    logic [WIDTH-1:0] ratio_active;
    logic             running;

    modport master (
        output en, load, div_ratio,
        input  div_out, div_out_n, tick, ratio_active, running
    );

    modport slave (
        input  en, load, div_ratio,
        output div_out, div_out_n, tick, ratio_active, running
    );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider producing a registered square
// wave (high for ceil(N/2) cycles, low for the rest), its complement and a
// one-cycle tick on the last cycle of each period. Ratio changes take effect
// only at a period boundary (or immediately while stopped), so no runt or
// stretched pulses appear. The outputs are data-path strobes, not clocks.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    clk_div_prog_if.slave (en, load, div_ratio in; div_out,
//          div_out_n, tick, ratio_active, running out)
module clk_div_prog #(
    parameter int WIDTH         = 8,
    parameter int DEFAULT_RATIO = 6
) (
    input  logic          clk,
    input  logic          reset,
    clk_div_prog_if.slave bus
);
    localparam logic [0:0] ST_STOP = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state, state_nx;
    logic [WIDTH-1:0] count, count_nx;
    logic [WIDTH-1:0] ratio, ratio_nx;
    logic [WIDTH-1:0] pend_val, pend_val_nx;
    logic             pending, pending_nx;
    logic             div_q, tick_q;

    logic             eff_pend;
    logic [WIDTH-1:0] eff_val;
    logic             stop_req;
    logic             at_boundary;
    logic [WIDTH:0]   half_nx;
    logic             div_nx, tick_nx;

    always_comb begin
        // A load in the current cycle overrides whatever is pending, so a
        // load on the boundary cycle shapes the period starting at that edge.
        eff_pend    = bus.load | pending;
        eff_val     = bus.load ? bus.div_ratio : pend_val;
        stop_req    = eff_pend && (eff_val == '0);
        at_boundary = (state == ST_RUN) && (count == ratio - WIDTH'(1));

        state_nx    = state;
        count_nx    = count;
        ratio_nx    = ratio;
        pending_nx  = eff_pend;
        pend_val_nx = eff_val;

        if ((state == ST_STOP) || at_boundary) begin
            if (eff_pend && !stop_req) begin
                ratio_nx   = (eff_val == WIDTH'(1)) ? WIDTH'(2) : eff_val;
                pending_nx = 1'b0;
            end
            // A pending zero ratio stays pending and holds the divider in
            // STOP until a nonzero ratio is loaded.
            count_nx = '0;
            state_nx = (bus.en && !stop_req) ? ST_RUN : ST_STOP;
        end else begin
            count_nx = count + WIDTH'(1);
        end

        // Outputs are registered from the next-state view so they are
        // clean flop outputs aligned with count.
        half_nx = ({1'b0, ratio_nx} + (WIDTH+1)'(1)) >> 1;
        div_nx  = (state_nx == ST_RUN) && ({1'b0, count_nx} < half_nx);
        tick_nx = (state_nx == ST_RUN) && (count_nx == ratio_nx - WIDTH'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_STOP;
            count    <= '0;
            ratio    <= WIDTH'(DEFAULT_RATIO);
            pend_val <= '0;
            pending  <= 1'b0;
            div_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            ratio    <= ratio_nx;
            pend_val <= pend_val_nx;
            pending  <= pending_nx;
            div_q    <= div_nx;
            tick_q   <= tick_nx;
        end
    end

    assign bus.div_out      = div_q;
    assign bus.div_out_n    = ~div_q;
    assign bus.tick         = tick_q;
    assign bus.ratio_active = ratio;
    assign bus.running      = (state == ST_RUN);
endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog: reference model in terms of "position within
// the current period" plus directed scenarios with literal waveforms and a
// randomized run.
module tb_clk_div_prog;
    localparam int W   = 8;
    localparam int DEF = 6;

    bit   clk = 1'b0;
    logic reset;

    clk_div_prog_if #(.WIDTH(W)) bus ();

    clk_div_prog #(.WIDTH(W), .DEFAULT_RATIO(DEF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cycle      = 0;

    // Reference model state
    bit m_run;
    int m_p;      // position within current period
    int m_n;      // active ratio
    bit m_pend;
    int m_pv;

    task automatic model_edge();
        if (!reset) begin
            m_run = 0; m_p = 0; m_n = DEF; m_pend = 0; m_pv = 0;
            return;
        end
        if (bus.load) begin
            m_pend = 1;
            m_pv   = int'(bus.div_ratio);
        end
        if (!m_run || m_p == m_n - 1) begin
            if (m_pend && m_pv != 0) begin
                m_n    = (m_pv < 2) ? 2 : m_pv;
                m_pend = 0;
            end
            m_run = bus.en && !(m_pend && m_pv == 0);
            m_p   = 0;
        end else begin
            m_p++;
        end
    endtask

    task automatic compare();
        bit exp_d, exp_t;
        exp_d = m_run && (m_p < (m_n + 1) / 2);
        exp_t = m_run && (m_p == m_n - 1);
        vectors++;
        if (bus.div_out !== exp_d) begin
            miscompares++;
            $display("FAIL div_out cycle %0d: got %b expected %b", cycle, bus.div_out, exp_d);
        end
        if (bus.div_out_n !== !exp_d) begin
            miscompares++;
            $display("FAIL div_out_n cycle %0d: got %b expected %b", cycle, bus.div_out_n, !exp_d);
        end
        if (bus.tick !== exp_t) begin
            miscompares++;
            $display("FAIL tick cycle %0d: got %b expected %b", cycle, bus.tick, exp_t);
        end
        if (bus.running !== m_run) begin
            miscompares++;
            $display("FAIL running cycle %0d: got %b expected %b", cycle, bus.running, m_run);
        end
        if (bus.ratio_active !== W'(m_n)) begin
            miscompares++;
            $display("FAIL ratio_active cycle %0d: got %0d expected %0d", cycle, bus.ratio_active, m_n);
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cycle++;
        compare();
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        while (bus.tick !== 1'b1 && n < 600) begin
            step();
            n++;
        end
        if (bus.tick !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got no tick expected tick within 600 cycles", name);
        end
    endtask

    initial begin
        logic [31:0] v, t;
        reset = 1'b0;
        bus.en = 1'b0;
        bus.load = 1'b0;
        bus.div_ratio = '0;

        // Reset state
        repeat (3) step();
        check_lit("reset_div_out_n", 32'(bus.div_out_n), 32'd1);
        check_lit("reset_ratio", 32'(bus.ratio_active), 32'd6);

        // Scenario 1: release with en=1 at default ratio 6
        reset = 1'b1;
        bus.en = 1'b1;
        v = '0; t = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            v = {v[30:0], bus.div_out};
            t = {t[30:0], bus.tick};
        end
        check_lit("s1_wave", v, 32'b111000111000);
        check_lit("s1_tick", t, 32'b000001000001);

        // Boundary load of 4: the very next period is already N=4
        wait_tick("s3a_wait");
        bus.load = 1'b1; bus.div_ratio = 8'd4;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.load = 1'b0;
            v = {v[30:0], bus.div_out};
        end
        check_lit("s3_boundary_load", v, 32'b1100);

        // Load 3 at count=1 of an N=4 period
        wait_tick("s3b_wait");
        v = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                bus.load = 1'b1; bus.div_ratio = 8'd3;
            end
            step();
            bus.load = 1'b0;
            v = {v[30:0], bus.div_out};
        end
        check_lit("s3_midperiod_load", v, 32'b1100110110);
        check_lit("s3_ratio", 32'(bus.ratio_active), 32'd3);

        // Scenario 4: en=0 at count=1 of N=6 finishes the period
        wait_tick("s4_wait");
        bus.load = 1'b1; bus.div_ratio = 8'd6;
        step();
        bus.load = 1'b0;
        step();
        bus.en = 1'b0;
        v = '0; t = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            v = {v[30:0], bus.div_out};
            t = {t[30:0], bus.tick};
        end
        check_lit("s4_wave", v, 32'b10000);
        check_lit("s4_tick", t, 32'b00010);
        check_lit("s4_running", 32'(bus.running), 32'd0);

        // Scenario 2: load 5 while stopped, then run
        bus.load = 1'b1; bus.div_ratio = 8'd5;
        step();
        bus.load = 1'b0;
        check_lit("s2_ratio", 32'(bus.ratio_active), 32'd5);
        bus.en = 1'b1;
        v = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            v = {v[30:0], bus.div_out};
        end
        check_lit("s2_wave", v, 32'b1110011100);

        // Scenario 5: ratio 1 clamps to 2, ratio 0 stops
        bus.load = 1'b1; bus.div_ratio = 8'd1;
        step();
        bus.load = 1'b0;
        wait_tick("s5_wait");
        v = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            v = {v[30:0], bus.div_out};
        end
        check_lit("s5_clamp_wave", v, 32'b1010);
        bus.load = 1'b1; bus.div_ratio = 8'd0;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 20 && bus.running === 1'b1; i++) step();
        check_lit("s5_stopped", 32'(bus.running), 32'd0);
        check_lit("s5_ratio_kept", 32'(bus.ratio_active), 32'd2);

        // Scenario 6: async reset at count=2 with N=7
        bus.load = 1'b1; bus.div_ratio = 8'd7;
        step();
        bus.load = 1'b0;
        step();
        step();
        @(posedge clk);
        model_edge();
        #2 reset = 1'b0;
        #1;
        model_edge();
        compare();
        check_lit("s6_async_div_out", 32'(bus.div_out), 32'd0);
        check_lit("s6_async_ratio", 32'(bus.ratio_active), 32'd6);
        @(negedge clk);
        step();
        reset = 1'b1;
        v = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            v = {v[30:0], bus.div_out};
        end
        check_lit("s6_resume_wave", v, 32'b111000);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            bus.en   = ($urandom_range(0, 9) != 0);
            bus.load = ($urandom_range(0, 7) == 0);
            bus.div_ratio = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                                         : W'($urandom_range(0, 9));
            step();
        end
        bus.load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider; successor to the fixed divide-by-2/4/6 flops.
- Produces a divided square wave, its complement and a one-cycle period tick, all registered in the `clk` domain.
- Supports even and odd ratios, glitch-free ratio changes and a graceful stop.
- Feeds slow-strobe and enable logic elsewhere in the design; the output is a data-path strobe/level, not a routed clock.

Parameters:
- WIDTH, 8, width of the ratio and of the internal period counter; maximum ratio 2^WIDTH-1.
- DEFAULT_RATIO, 6, ratio in effect after reset; legal range 2..2^WIDTH-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  run request; 1 = divide, 0 = stop at the next period boundary.
- load  input  1  one-cycle strobe; captures div_ratio.
- div_ratio  input  WIDTH  requested ratio N.
- div_out  output  1  divided square wave.
- div_out_n  output  1  always ~div_out, including during reset.
- tick  output  1  one-cycle pulse on the last cycle of each period.
- ratio_active  output  WIDTH  ratio currently in use.
- running  output  1  1 while the divider is in the RUN state.

Behaviour:
- **Reset (reset=0, asynchronous)**
  - count=0, state=STOP, pending=0.
  - div_out=0, div_out_n=1, tick=0, running=0, ratio_active=DEFAULT_RATIO.
  - Reset asserted mid-period aborts immediately; no partial period completes.
- **Ratio rules**
  - Loaded value 1 is clamped to 2.
  - Loaded value 0 means "stop": at the next boundary go to STOP; ratio_active keeps its previous nonzero value.
- **Period shape** (ratio N)
  - count runs 0..N-1.
  - div_out=1 while count < H, where H=(N+1)>>1; otherwise div_out=0.
  - Resulting high/low cycles: N=6 gives 3/3; N=5 gives 3/2; N=2 gives 1/1.
  - Boundary = cycle with count==N-1; tick=1 exactly there, and only in RUN.
- **State STOP**
  - Outputs: div_out=0, tick=0, running=0, count held at 0.
  - At the first rising edge with en=1 (and no pending zero ratio): go to RUN; that edge sets count=0, div_out=1, running=1.
  - Latency from en sampled high to div_out high: the same edge (registered, one-cycle visible delay).
- **State RUN**
  - count increments every cycle; at the boundary it wraps to 0.
  - If en=0 at the boundary edge: go to STOP, div_out=0, running=0.
  - en dropped mid-period: the period finishes fully; no truncation.
- **Load handling**
  - load=1 captures div_ratio into a pending register and sets pending=1.
  - In STOP, a load applies immediately: ratio_active updates on the next edge.
  - In RUN, a load applies at the next boundary edge: the new period uses the new N, and pending clears.
  - Load on the boundary cycle itself: the value applies to the period starting on that edge.
  - Several loads before a boundary: the last one wins.
  - Load together with en falling on the boundary: the ratio is updated, then STOP.
- **Arithmetic**
  - Counter and compare are WIDTH bits; no overflow is possible since N ≤ 2^WIDTH-1.
  - H is computed with one extra bit internally.
- **Glitch rules**
  - div_out changes only at H and at the boundary.
  - No runt or extended pulse on a ratio change.

Test Plan:
1. Reset release with en=1 and default ratio 6:
   - div_out pattern 111000 repeating.
   - tick high on every 6th cycle (count=5).
   - div_out_n is the exact complement; running=1.
2. load div_ratio=5 in STOP, then en=1:
   - div_out 11100 repeating; tick every 5 cycles; ratio_active=5.
3. Running at N=4, load N=3 at count=1:
   - Current period completes as 1100.
   - Following periods are 110; ratio_active changes on the boundary edge.
   - Repeat with the load on the boundary cycle: the next period is already 110.
4. en=0 at count=1 of an N=6 period:
   - Period completes (tick at count=5), then div_out=0 and running=0.
   - en=1 later restarts with div_out=1 on the sampling edge.
5. load 1, then load 0, in RUN at N=6:
   - Ratio 1 gives period 10 (clamped to 2).
   - Ratio 0 gives STOP at the next boundary, with ratio_active still 2.
6. reset asserted asynchronously at count=2 with N=7:
   - Outputs go to reset values without waiting for clk.
   - After release, ratio_active=6 and operation resumes per scenario 1.
